// File: rtl/key_loader_pkg.sv
// Shared types and helpers for the serial key loader and its bench model.
package key_loader_pkg;

    localparam int unsigned CHK_WIDTH     = 8;
    // Widest key the fold helper accepts; narrower keys are zero-extended, which leaves the fold unchanged.
    localparam int unsigned MAX_KEY_WIDTH = 256;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StCheck,
        StDone,
        StLock
    } state_e;

    function automatic logic [CHK_WIDTH-1:0] xor_fold(input logic [MAX_KEY_WIDTH-1:0] key);
        logic [CHK_WIDTH-1:0] acc;
        acc = '0;
        for (int unsigned k = 0; k < MAX_KEY_WIDTH / CHK_WIDTH; k++) begin
            acc = acc ^ key[k*CHK_WIDTH +: CHK_WIDTH];
        end
        return acc;
    endfunction

endpackage

// File: rtl/key_shift_rx.sv
// Serial-in receiver: collects KEY_WIDTH key bits then CHK_WIDTH checksum bits, LSB first.
module key_shift_rx
    import key_loader_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 sdata_i,
    input  logic                 svalid_i,
    output logic                 sready_o,
    output logic                 done_o,
    output logic [KEY_WIDTH-1:0] key_o,
    output logic [CHK_WIDTH-1:0] chk_o
);

    localparam int unsigned TotBits = KEY_WIDTH + CHK_WIDTH;
    localparam int unsigned CntW    = $clog2(TotBits);

    logic [TotBits-1:0] sr_q, sr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               active_q, active_d;
    logic               take;

    assign take   = active_q & svalid_i;
    assign done_o = take & (cnt_q == CntW'(TotBits - 1));

    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            sr_d     = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (take) begin
            // Shift right so the first bit received settles at bit 0.
            sr_d  = {sdata_i, sr_q[TotBits-1:1]};
            cnt_d = cnt_q + CntW'(1);
            if (done_o) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign sready_o = active_q;
    assign key_o    = sr_q[KEY_WIDTH-1:0];
    assign chk_o    = sr_q[TotBits-1 -: CHK_WIDTH];

endmodule

// File: rtl/key_loader.sv
// Checksum-verified key provisioning for locked netlists, with a volatile failed-load lockout.
module key_loader
    import key_loader_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = 24,
    parameter int unsigned MAX_FAIL  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start_i,
    input  logic                 sdata_i,
    input  logic                 svalid_i,
    output logic                 sready_o,
    output logic [KEY_WIDTH-1:0] key_out_o,
    output logic                 key_valid_o,
    output logic                 load_err_o,
    output logic                 locked_out_o,
    output logic                 busy_o
);

    if ((KEY_WIDTH % CHK_WIDTH) != 0 || KEY_WIDTH == 0 || KEY_WIDTH > MAX_KEY_WIDTH) begin : g_bad_width
        $error("key_loader: KEY_WIDTH must be a non-zero multiple of 8");
    end
    if (MAX_FAIL < 1 || MAX_FAIL > 15) begin : g_bad_fail
        $error("key_loader: MAX_FAIL must be in 1..15");
    end

    state_e               state_q, state_d;
    logic [3:0]           fail_q, fail_d, fail_inc;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic                 load_err_q, load_err_d;
    logic                 locked_q, locked_d;
    logic                 busy_q, busy_d;

    logic                 rx_start;
    logic                 rx_done;
    logic                 rx_sready;
    logic [KEY_WIDTH-1:0] rx_key;
    logic [CHK_WIDTH-1:0] rx_chk;
    logic                 chk_ok;

    key_shift_rx #(
        .KEY_WIDTH (KEY_WIDTH)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (rx_start),
        .sdata_i  (sdata_i),
        .svalid_i (svalid_i),
        .sready_o (rx_sready),
        .done_o   (rx_done),
        .key_o    (rx_key),
        .chk_o    (rx_chk)
    );

    assign chk_ok   = (xor_fold(MAX_KEY_WIDTH'(rx_key)) == rx_chk);
    assign fail_inc = fail_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        fail_d      = fail_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        load_err_d  = 1'b0;
        locked_d    = locked_q;
        rx_start    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start_i) begin
                    rx_start = 1'b1;
                    state_d  = StShift;
                end
            end
            StShift: begin
                if (rx_done) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (chk_ok) begin
                    key_d       = rx_key;
                    key_valid_d = 1'b1;
                    fail_d      = '0;
                    state_d     = StDone;
                end else begin
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    load_err_d  = 1'b1;
                    fail_d      = fail_inc;
                    if (fail_inc == 4'(MAX_FAIL)) begin
                        locked_d = 1'b1;
                        state_d  = StLock;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDone: begin
                if (load_start_i) begin
                    // Drop the old key the moment a reload starts.
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    rx_start    = 1'b1;
                    state_d     = StShift;
                end
            end
            StLock: begin
                key_d       = '0;
                key_valid_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d == StShift) || (state_d == StCheck);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            fail_q      <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            load_err_q  <= 1'b0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fail_q      <= fail_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            load_err_q  <= load_err_d;
            locked_q    <= locked_d;
            busy_q      <= busy_d;
        end
    end

    assign sready_o     = rx_sready;
    assign key_out_o    = key_q;
    assign key_valid_o  = key_valid_q;
    assign load_err_o   = load_err_q;
    assign locked_out_o = locked_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: vector table, lockout/reset sequences, random loads vs. a model.
module tb_key_loader;

    localparam int unsigned KW   = 24;
    localparam int unsigned MAXF = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          sdata = 1'b0;
    logic          svalid = 1'b0;
    logic          sready;
    logic [KW-1:0] key_out;
    logic          key_valid;
    logic          load_err;
    logic          locked_out;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int            m_fail   = 0;
    bit            m_locked = 1'b0;
    bit            m_valid  = 1'b0;
    logic [KW-1:0] m_key    = '0;

    key_loader #(
        .KEY_WIDTH (KW),
        .MAX_FAIL  (MAXF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start_i (load_start),
        .sdata_i      (sdata),
        .svalid_i     (svalid),
        .sready_o     (sready),
        .key_out_o    (key_out),
        .key_valid_o  (key_valid),
        .load_err_o   (load_err),
        .locked_out_o (locked_out),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] key;
        logic [7:0]  ck;
        int          gap;
        bit          ok;
    } vec_t;

    function automatic logic [7:0] model_fold(input logic [23:0] k);
        return k[7:0] ^ k[15:8] ^ k[23:16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        load_start = 1'b0;
        svalid     = 1'b0;
        sdata      = 1'b0;
        #2;
        chk("reset_flags", {27'd0, sready, key_valid, load_err, locked_out, busy}, 32'd0);
        chk("reset_key", {8'd0, key_out}, 32'd0);
        tick();
        tick();
        rst_n    = 1'b1;
        m_fail   = 0;
        m_locked = 1'b0;
        m_valid  = 1'b0;
        m_key    = '0;
        tick();
    endtask

    // gap: 0 = svalid constant, 1 = two idle cycles between bits, 2 = random gaps and stray load_start.
    task automatic do_load(input logic [23:0] key, input logic [7:0] ck, input int gap);
        logic [31:0] stream;
        bit          ok;
        int          n;
        stream     = {ck, key};
        ok         = (model_fold(key) == ck);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        if (m_locked) begin
            chk("lock_ignore", {28'd0, sready, key_valid, busy, locked_out}, 32'h1);
            chk("lock_key", {8'd0, key_out}, 32'd0);
            svalid = 1'b1;
            sdata  = 1'b1;
            tick();
            svalid = 1'b0;
            chk("lock_stay", {28'd0, sready, key_valid, busy, locked_out}, 32'h1);
            return;
        end
        chk("shift_entry", {28'd0, sready, load_err, key_valid, busy}, 32'h9);
        chk("shift_entry_key", {8'd0, key_out}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            n = 0;
            if (gap == 1 && i > 0) n = 2;
            else if (gap == 2) n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) begin
                svalid     = 1'b0;
                sdata      = 1'($urandom);
                load_start = (gap == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
                tick();
                chk("gap_hold", {28'd0, sready, load_err, key_valid, busy}, 32'h9);
                chk("gap_key", {8'd0, key_out}, 32'd0);
            end
            svalid     = 1'b1;
            sdata      = stream[i];
            load_start = (gap == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            if (i < 31) begin
                chk("shift_run", {28'd0, sready, load_err, key_valid, busy}, 32'h9);
                chk("shift_key", {8'd0, key_out}, 32'd0);
            end
        end
        svalid     = 1'b0;
        sdata      = 1'b0;
        load_start = (gap == 2) ? ($urandom_range(0, 1) == 0) : 1'b0;
        chk("check_state", {28'd0, sready, load_err, key_valid, busy}, 32'h1);
        chk("check_key", {8'd0, key_out}, 32'd0);
        tick();
        load_start = 1'b0;
        if (ok) begin
            m_fail  = 0;
            m_valid = 1'b1;
            m_key   = key;
        end else begin
            m_fail++;
            m_valid = 1'b0;
            m_key   = '0;
            if (m_fail == MAXF) m_locked = 1'b1;
        end
        chk("commit_flags", {27'd0, sready, load_err, key_valid, busy, locked_out},
            {27'd0, 1'b0, !ok, ok, 1'b0, m_locked});
        chk("commit_key", {8'd0, key_out}, {8'd0, m_key});
        tick();
        chk("after_flags", {29'd0, load_err, key_valid, locked_out}, {29'd0, 1'b0, m_valid, m_locked});
        chk("after_key", {8'd0, key_out}, {8'd0, m_key});
    endtask

    vec_t vecs[9];

    initial begin
        logic [23:0] rk;
        logic [7:0]  rc;

        vecs[0] = '{24'hA5C33C, 8'h5A, 0, 1'b1};
        vecs[1] = '{24'hA5C33C, 8'h5A, 1, 1'b1};
        vecs[2] = '{24'hA5C33C, 8'h5B, 0, 1'b0};
        vecs[3] = '{24'hA5C33C, 8'h5A, 0, 1'b1};
        vecs[4] = '{24'h00FF01, 8'hFE, 0, 1'b1};
        vecs[5] = '{24'h000000, 8'h00, 1, 1'b1};
        vecs[6] = '{24'h123456, 8'h71, 0, 1'b0};
        vecs[7] = '{24'hFFFFFF, 8'h00, 2, 1'b0};
        vecs[8] = '{24'h123456, 8'h70, 2, 1'b1};

        tick();
        do_reset();

        for (int v = 0; v < 9; v++) begin
            chk("vec_table_ok", {31'd0, model_fold(vecs[v].key) == vecs[v].ck}, {31'd0, vecs[v].ok});
            do_load(vecs[v].key, vecs[v].ck, vecs[v].gap);
            chk("vec_result", {31'd0, key_valid}, {31'd0, vecs[v].ok});
        end

        // Three consecutive bad loads lock; a good stream is then refused.
        for (int b = 0; b < 3; b++) do_load(24'hA5C33C, 8'h5B, 0);
        chk("locked_after_3", {31'd0, locked_out}, 32'd1);
        do_load(24'hA5C33C, 8'h5A, 0);
        chk("locked_no_key", {31'd0, key_valid}, 32'd0);
        do_reset();
        chk("lock_cleared", {31'd0, locked_out}, 32'd0);

        // Reset after 10 bits aborts the load.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            svalid = 1'b1;
            sdata  = 1'($urandom);
            tick();
        end
        do_reset();
        do_load(24'hA5C33C, 8'h5A, 0);
        chk("post_abort_key", {8'd0, key_out}, 32'h00A5C33C);

        for (int r = 0; r < 40; r++) begin
            rk = 24'($urandom);
            rc = ($urandom_range(0, 2) == 0) ? 8'($urandom) : model_fold(rk);
            do_load(rk, rc, $urandom_range(0, 2));
            if (m_locked) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
